vote_ctrl: RTL

- Session controller for the 3-input majority voter datapath, Y = AB + BC + AC.
- Opens a timed voting window on START and latches one vote per voter (A, B, C).
- Closes the window on all-voted or timeout, evaluates the majority through the voter, then holds the registered result for a fixed display period.
- Sits between the push-button/debounce front end and the result LED/display logic.

---
 rtl/vote_pkg.sv | 13 +
 rtl/maj3.sv | 9 +
 rtl/vote_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// vote_pkg: shared FSM state encoding, voter indices and default timer width for vote_ctrl
package vote_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_SHOW    = 2'd3
  } state_e;
  localparam int IDX_A     = 0;
  localparam int IDX_B     = 1;
  localparam int IDX_C     = 2;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/maj3.sv
// maj3: 3-input majority voter, y = ab + bc + ac
module maj3 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);
  assign y_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
endmodule

// File: rtl/vote_ctrl.sv
// vote_ctrl: timed 3-voter session controller; VOTE_CTRL_REVOTE_EN selects last-vote-wins with timer-only close
module vote_ctrl
  import vote_pkg::*;
#(
  parameter int WINDOW_CYCLES = 100,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       vote_a_vld_i,
  input  logic       vote_a_yes_i,
  input  logic       vote_b_vld_i,
  input  logic       vote_b_yes_i,
  input  logic       vote_c_vld_i,
  input  logic       vote_c_yes_i,
  output logic       busy_o,
  output logic [2:0] voted_o,
  output logic       result_o,
  output logic       result_vld_o,
  output logic       timeout_o
);
  localparam logic [CNT_W-1:0] WIN_LD  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       votes_q, votes_d, voted_q, voted_d;
  logic [2:0]       vld, yes, take, votes_c, voted_c;
  logic             result_q, result_d, timeout_q, timeout_d, maj_y, close;
  // gather voter strobes and values into index-ordered vectors
  always_comb begin
    vld        = '0;
    yes        = '0;
    vld[IDX_A] = vote_a_vld_i;
    vld[IDX_B] = vote_b_vld_i;
    vld[IDX_C] = vote_c_vld_i;
    yes[IDX_A] = vote_a_yes_i;
    yes[IDX_B] = vote_b_yes_i;
    yes[IDX_C] = vote_c_yes_i;
  end
  // which strobes overwrite a latched vote, and whether this COLLECT cycle is the last
  always_comb begin
`ifdef VOTE_CTRL_REVOTE_EN
    take  = vld;
    close = timer_q == '0;
`else
    take  = vld & ~voted_q;
    close = (timer_q == '0) || ((voted_q | vld) == 3'b111);
`endif
    votes_c = (votes_q & ~take) | (yes & take);
    voted_c = voted_q | vld;
  end
  maj3 u_maj3 (
    .a_i(votes_q[IDX_A]),
    .b_i(votes_q[IDX_B]),
    .c_i(votes_q[IDX_C]),
    .y_o(maj_y)
  );
  // session FSM: next state, timer and vote/result updates
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    votes_d   = votes_q;
    voted_d   = voted_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = WIN_LD;
        if (start_i) begin
          state_d   = ST_COLLECT;
          votes_d   = '0;
          voted_d   = '0;
          result_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        timer_d = timer_q - ONE;
        votes_d = votes_c;
        voted_d = voted_c;
        state_d = close ? ST_DECIDE : ST_COLLECT;
      end
      ST_DECIDE: begin
        result_d  = maj_y;
        timeout_d = voted_q != 3'b111;
        timer_d   = HOLD_LD;
        state_d   = ST_SHOW;
      end
      ST_SHOW: begin
        timer_d = timer_q - ONE;
        state_d = (timer_q == '0) ? ST_IDLE : ST_SHOW;
      end
    endcase
  end
  // state and datapath registers; reset aborts any session in progress
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      votes_q   <= '0;
      voted_q   <= '0;
      result_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      votes_q   <= votes_d;
      voted_q   <= voted_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end
  assign busy_o       = state_q != ST_IDLE;
  assign result_vld_o = state_q == ST_SHOW;
  assign voted_o      = voted_q;
  assign result_o     = result_q;
  assign timeout_o    = timeout_q;
endmodule
